ram_rr_arbiter: RTL

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ram_rr_arbiter.sv
// Two independent round-robin arbiters (write and read) sharing a simple dual-port RAM.
// Reads have a fixed 2-cycle response latency; the all-ones address is unbacked and flagged.
module ram_rr_arbiter #(
    parameter int ADDR_WIDTH = 1,
    parameter int WORD_SIZE  = 1,
    parameter int NREQ       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*WORD_SIZE-1:0]  req_wdata,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic                       rsp_err,
    output logic [WORD_SIZE-1:0]       rsp_data,
    output logic                       ram_we,
    output logic [ADDR_WIDTH-1:0]      ram_waddr,
    output logic [WORD_SIZE-1:0]       ram_wdata,
    output logic [ADDR_WIDTH-1:0]      ram_raddr,
    input  logic [WORD_SIZE-1:0]       ram_q,
    output logic [15:0]                err_cnt
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Returns {found, index} of the first candidate at or after ptr, wrapping modulo NREQ.
    function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] cand,
                                               input logic [PTR_W-1:0] ptr);
        logic             found;
        logic [PTR_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            k = int'(ptr) + off;
            if (k >= NREQ) k = k - NREQ;
            if (!found && cand[k[PTR_W-1:0]]) begin
                found = 1'b1;
                idx   = k[PTR_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_WIDTH-1:0] addr_arr  [NREQ];
    logic [WORD_SIZE-1:0]  wdata_arr [NREQ];

    logic                  wr_found, rd_found;
    logic [PTR_W-1:0]      wr_idx, rd_idx;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [WORD_SIZE-1:0]  wr_data;
    logic                  wr_acc, rd_acc, conflict;
    logic                  wr_unb, rd_unb;
    logic [NREQ-1:0]       wr_gnt, rd_gnt;

    logic [NREQ-1:0]       rd_pend;
    logic                  rd_pend_err;
    logic [1:0]            err_inc;
    logic [16:0]           err_sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = req_wdata[i*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_comb begin
        {wr_found, wr_idx} = rr_pick(req_valid & req_we, wr_ptr);
        {rd_found, rd_idx} = rr_pick(req_valid & ~req_we, rd_ptr);
        wr_addr = addr_arr[wr_idx];
        wr_data = wdata_arr[wr_idx];
        rd_addr = addr_arr[rd_idx];

        // A same-address read waits one cycle so it observes the write.
        conflict = wr_found && rd_found && (wr_addr == rd_addr);
        wr_acc   = rst_n && wr_found;
        rd_acc   = rst_n && rd_found && !conflict;
        wr_unb   = (wr_addr == '1);
        rd_unb   = (rd_addr == '1);

        wr_gnt = '0;
        rd_gnt = '0;
        if (wr_acc) wr_gnt[wr_idx] = 1'b1;
        if (rd_acc) rd_gnt[rd_idx] = 1'b1;
        req_ready = wr_gnt | rd_gnt;

        err_inc = {1'b0, wr_acc && wr_unb} + {1'b0, rd_acc && rd_unb};
        err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_we      <= 1'b0;
            ram_waddr   <= '0;
            ram_wdata   <= '0;
            ram_raddr   <= '0;
            rd_pend     <= '0;
            rd_pend_err <= 1'b0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr    <= ptr_after(wr_idx);
                ram_waddr <= wr_addr;
                ram_wdata <= wr_data;
            end
            ram_we <= wr_acc && !wr_unb;

            if (rd_acc) begin
                rd_ptr    <= ptr_after(rd_idx);
                ram_raddr <= rd_addr;
            end
            rd_pend     <= rd_gnt;
            rd_pend_err <= rd_acc && rd_unb;
            rsp_valid   <= rd_pend;
            rsp_err     <= rd_pend_err;

            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // ram_q arrives in the response cycle; unbacked reads return zero.
    assign rsp_data = (|rsp_valid && !rsp_err) ? ram_q : '0;

endmodule
